// File: rtl/seq_mul_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, sign fix-up in a final cycle, plus direct MTHI/MTLO writes.
module seq_mul_div_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_x,
  input  logic [WIDTH-1:0] data_y,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               is_div, neg_q, neg_r, div_zero;

  logic               op_mul, op_div, op_signed, accept, x_neg, y_neg;
  logic [WIDTH-1:0]   mag_x, mag_y;
  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign op_mul    = (op == 3'd0) || (op == 3'd1);
  assign op_div    = (op == 3'd2) || (op == 3'd3);
  assign op_signed = (op == 3'd0) || (op == 3'd2);
  assign accept    = start && (state == S_IDLE) && !flush;
  assign stall     = start && busy;

  assign x_neg = op_signed && data_x[WIDTH-1];
  assign y_neg = op_signed && data_y[WIDTH-1];
  assign mag_x = x_neg ? -data_x : data_x;
  assign mag_y = y_neg ? -data_y : data_y;

  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  assign div_trial = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, opnd};
  assign div_ge    = !div_diff[WIDTH];
  assign div_step  = {div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0],
                      acc[WIDTH-2:0], div_ge};

  // Divide-by-zero forces an all-ones quotient regardless of sign; the remainder
  // path already reproduces the original dividend.
  assign prod_fix = neg_q ? -acc : acc;
  assign q_fix    = div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) begin
        if (op_mul)      state_nx = FAST_MUL ? S_FIX : S_MUL;
        else if (op_div) state_nx = S_DIV;
      end
      S_MUL, S_DIV: if (counter == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      counter <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= (state == S_FIX) && !flush;
      if (accept) begin
        counter <= CNT_MAX;
        if (op == 3'd4) hi <= data_x;
        if (op == 3'd5) lo <= data_x;
      end else if (state == S_MUL || state == S_DIV) begin
        counter <= counter - 1'b1;
      end
      if (state == S_FIX && !flush) begin
        if (is_div) {hi, lo} <= {r_fix, q_fix};
        else        {hi, lo} <= prod_fix;
      end
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on acceptance
  // before any state that reads them.
  always_ff @(posedge clk) begin
    if (accept && (op_mul || op_div)) begin
      opnd     <= op_mul ? mag_x : mag_y;
      neg_q    <= x_neg ^ y_neg;
      neg_r    <= x_neg;
      is_div   <= op_div;
      div_zero <= (data_y == '0);
      if (op_mul && FAST_MUL)
        acc <= {{WIDTH{1'b0}}, mag_x} * {{WIDTH{1'b0}}, mag_y};
      else
        acc <= {{WIDTH{1'b0}}, op_mul ? mag_y : mag_x};
    end else if (state == S_MUL) begin
      acc <= mul_step;
    end else if (state == S_DIV) begin
      acc <= div_step;
    end
  end

endmodule
